// File: rtl/bus_txn_initiator.sv
// Initiator end of the req/rw/ack/done bus handshake with per-transaction timeout and status.
// Define BUS_TXN_INITIATOR_RETRY_EN to reissue timed-out commands after an idle gap.
module bus_txn_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRY      = 2,
    parameter int GAP_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_rw,
    output logic       cmd_ready,
    output logic       req,
    output logic       rw,
    input  logic       ack,
    input  logic       busy,
    input  logic       done,
    input  logic       data_valid,
    output logic       rsp_valid,
    output logic       rsp_ok,
    output logic       rsp_timeout,
    output logic [7:0] txn_count,
    output logic [7:0] err_count
);

`ifdef BUS_TXN_INITIATOR_RETRY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RSP  = 3'd3,
        S_GAP  = 3'd4
    } state_t;
    logic [7:0] r_retry;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;
    logic [7:0] w_unused_cfg;
    assign w_unused_cfg = 8'(MAX_RETRY + GAP_CYCLES);
`endif

    state_t     r_state;
    logic [7:0] r_timer;
    logic       r_req;
    logic       r_rw;
    logic       r_rsp_valid;
    logic       r_rsp_ok;
    logic       r_rsp_timeout;
    logic [7:0] r_txn_count;
    logic [7:0] r_err_count;
    logic       w_timer_end;
    logic       w_timeout;
    logic       w_unused_busy;

    // The responder's busy flag is observed by the host side only.
    assign w_unused_busy = busy;

    // done outranks both ack and the timer, so a completing transaction never times out.
    assign w_timer_end = (r_timer == 8'(TIMEOUT_CYCLES - 1));
    assign w_timeout   = w_timer_end && !done &&
                         (((r_state == S_REQ) && !ack) || (r_state == S_WAIT));

    assign cmd_ready   = (r_state == S_IDLE);
    assign req         = r_req;
    assign rw          = r_rw;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_ok      = r_rsp_ok;
    assign rsp_timeout = r_rsp_timeout;
    assign txn_count   = r_txn_count;
    assign err_count   = r_err_count;

    // NOTE: every state register uses non-blocking assignment so all of them
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_req         <= 1'b0;
            r_rw          <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_ok      <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_txn_count   <= '0;
            r_err_count   <= '0;
`ifdef BUS_TXN_INITIATOR_RETRY_EN
            r_retry       <= '0;
`endif
        end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_timer <= '0;
`ifdef BUS_TXN_INITIATOR_RETRY_EN
            if (r_retry < 8'(MAX_RETRY)) begin
                r_retry <= r_retry + 8'd1;
                r_state <= S_GAP;
            end else begin
                r_rsp_valid   <= 1'b1;
                r_rsp_ok      <= 1'b0;
                r_rsp_timeout <= 1'b1;
                r_state       <= S_RSP;
            end
`else
            r_rsp_valid   <= 1'b1;
            r_rsp_ok      <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RSP;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_rw    <= cmd_rw;
                        r_req   <= 1'b1;
                        r_timer <= '0;
`ifdef BUS_TXN_INITIATOR_RETRY_EN
                        r_retry <= '0;
`endif
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (done) begin
                        // done without ack is a protocol error regardless of data_valid.
                        r_req         <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_ok      <= ack && (data_valid == r_rw);
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RSP;
                    end else if (ack) begin
                        r_req   <= 1'b0;
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_ok      <= (data_valid == r_rw);
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RSP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_RSP: begin
                    r_rsp_valid <= 1'b0;
                    if (r_txn_count != 8'hFF) r_txn_count <= r_txn_count + 8'd1;
                    if (!r_rsp_ok && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
                    r_state <= S_IDLE;
                end
`ifdef BUS_TXN_INITIATOR_RETRY_EN
                S_GAP: begin
                    if (r_timer == 8'(GAP_CYCLES - 1)) begin
                        r_req   <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_REQ;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_txn_initiator.sv
// Directed self-checking bench for bus_txn_initiator with a small bus responder model.
// Retry expectations apply when BUS_TXN_INITIATOR_RETRY_EN is defined.
module tb_bus_txn_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic       cmd_ready, req, rw, rsp_valid, rsp_ok, rsp_timeout;
    logic       ack, busy, done, data_valid;
    logic [7:0] txn_count, err_count;

    int checks = 0;
    int failures = 0;

    // Responder model knobs: suppress ack, or return the wrong data_valid.
    logic m_no_ack = 1'b0;
    logic m_bad_dv = 1'b0;
    int   m_state;

    bus_txn_initiator #(
        .TIMEOUT_CYCLES(16),
        .MAX_RETRY     (2),
        .GAP_CYCLES    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_rw     (cmd_rw),
        .cmd_ready  (cmd_ready),
        .req        (req),
        .rw         (rw),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .data_valid (data_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ok     (rsp_ok),
        .rsp_timeout(rsp_timeout),
        .txn_count  (txn_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Responder: sees req, acks two edges later, then pulses done (+data_valid for reads).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state    <= 0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            case (m_state)
                0: begin
                    done       <= 1'b0;
                    data_valid <= 1'b0;
                    if (req && !m_no_ack) begin
                        busy    <= 1'b1;
                        m_state <= 1;
                    end
                end
                1: begin
                    ack     <= 1'b1;
                    m_state <= 2;
                end
                2: begin
                    ack     <= 1'b0;
                    m_state <= 3;
                end
                default: begin
                    done       <= 1'b1;
                    data_valid <= rw ^ m_bad_dv;
                    busy       <= 1'b0;
                    m_state    <= 0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command from IDLE and follows it up to the rsp_valid cycle.
    task automatic run_txn(input logic dir, output int req_cyc, output int req_rises, output int lat);
        logic prev;
        cmd_valid = 1'b1;
        cmd_rw    = dir;
        step();
        cmd_valid = 1'b0;
        req_cyc   = 0;
        req_rises = 0;
        lat       = 0;
        prev      = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (req) begin
                req_cyc++;
                if (!prev) req_rises++;
            end
            prev = req;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            step();
        end
        if (lat == 0) check("rsp_wait_bound", 0, 1);
    endtask

    initial begin
        int rc, rises, lat, seen, n, last, bad;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_req", req, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_txn", txn_count, 0);
        check("rst_err", err_count, 0);
        step();

        // Write
        run_txn(1'b0, rc, rises, lat);
        check("wr_req_cycles", rc, 3);
        check("wr_latency", lat, 6);
        check("wr_ok", rsp_ok, 1);
        check("wr_timeout", rsp_timeout, 0);
        check("wr_rw", rw, 0);
        step();
        check("wr_ready_after", cmd_ready, 1);
        check("wr_rsp_pulse", rsp_valid, 0);
        check("wr_txn", txn_count, 1);
        check("wr_err", err_count, 0);

        // Good read
        run_txn(1'b1, rc, rises, lat);
        check("rd_latency", lat, 6);
        check("rd_rw", rw, 1);
        check("rd_ok", rsp_ok, 1);
        step();
        check("rd_txn", txn_count, 2);
        check("rd_err", err_count, 0);

        // Read with wrong data_valid
        m_bad_dv = 1'b1;
        run_txn(1'b1, rc, rises, lat);
        check("rdbad_ok", rsp_ok, 0);
        check("rdbad_timeout", rsp_timeout, 0);
        step();
        m_bad_dv = 1'b0;
        check("rdbad_txn", txn_count, 3);
        check("rdbad_err", err_count, 1);

        // Ack never arrives
        m_no_ack = 1'b1;
        run_txn(1'b0, rc, rises, lat);
`ifdef BUS_TXN_INITIATOR_RETRY_EN
        check("to_req_cycles", rc, 48);
        check("to_req_windows", rises, 3);
        check("to_latency", lat, 57);
`else
        check("to_req_cycles", rc, 16);
        check("to_req_windows", rises, 1);
        check("to_latency", lat, 17);
`endif
        check("to_ok", rsp_ok, 0);
        check("to_timeout", rsp_timeout, 1);
        step();
        m_no_ack = 1'b0;
        check("to_ready_after", cmd_ready, 1);
        check("to_txn", txn_count, 4);
        check("to_err", err_count, 2);

        // Reset while waiting for done
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        check("mid_busy", cmd_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_rw", rw, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_ok", rsp_ok, 0);
        check("mid_rst_rsp_timeout", rsp_timeout, 0);
        check("mid_rst_txn", txn_count, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_ready", cmd_ready, 1);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid) seen++;
            step();
        end
        check("mid_rst_no_rsp", seen, 0);
        run_txn(1'b0, rc, rises, lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_ok", rsp_ok, 1);
        step();
        check("post_rst_txn", txn_count, 1);

        // 260 back-to-back writes
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        n    = 0;
        last = -1;
        bad  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cmd_ready) begin
                if (last >= 0 && (cyc - last) != 7) bad++;
                last = cyc;
                n++;
                if (n == 260) break;
            end
            step();
        end
        step();
        cmd_valid = 1'b0;
        check("b2b_accepts", n, 260);
        check("b2b_period_errs", bad, 0);
        repeat (10) step();
        check("b2b_txn_sat", txn_count, 255);
        check("b2b_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_txn_initiator.md
Name: bus_txn_initiator

Overview:
- Initiator (master) end of the single-wire req/rw bus handshake: accepts host commands, drives req/rw into the bus responder, tracks its ack/busy/done/data_valid replies.
- Enforces a timeout per transaction and checks the response for protocol correctness (data_valid must equal rw at done).
- Returns a one-cycle completion status to the host and keeps saturating transaction and error counters.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in REQ or WAIT before timeout (1..255).
- MAX_RETRY, 2, reissues after timeout (used only with RETRY_EN).
- GAP_CYCLES, 4, idle cycles with req=0 between a timeout and its reissue.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_rw  in  1  1=READ, 0=WRITE
- cmd_ready  out  1  initiator can accept a command (high only in IDLE)
- req  out  1  bus request to responder
- rw  out  1  bus direction, held stable for the whole transaction
- ack  in  1  responder acknowledge
- busy  in  1  responder busy (monitored only)
- done  in  1  responder completion pulse
- data_valid  in  1  responder read-data-valid pulse (coincident with done)
- rsp_valid  out  1  one-cycle completion pulse to host
- rsp_ok  out  1  completion status; qualified by rsp_valid
- rsp_timeout  out  1  completion caused by timeout; qualified by rsp_valid
- txn_count  out  8  completed transactions, saturating at 255
- err_count  out  8  failed transactions (timeout or protocol error), saturating at 255

Behaviour:
- Reset (asynchronous): state=IDLE; req=0, rw=0, rsp_valid=0, rsp_ok=0, rsp_timeout=0, txn_count=0, err_count=0; timeout and retry counters cleared. Reset mid-transaction drops req immediately with no response.
- All outputs are registered or decoded from registered state only; no combinational path from ack/done to req.
- Main states:
  - IDLE: cmd_ready=1, req=0. On cmd_valid, latch cmd_rw into rw, clear timer and retry count, go to REQ.
  - REQ: req=1. On ack, go to WAIT. On done before ack, protocol error, go to RSP with ok=0. When timer reaches TIMEOUT_CYCLES-1 without ack, timeout.
  - WAIT: req=0; timer restarts on entry. On done, rsp_ok = (data_valid == rw), go to RSP. When timer reaches TIMEOUT_CYCLES-1 without done, timeout.
  - RSP: rsp_valid=1 for exactly one cycle, then IDLE. txn_count increments on every RSP; err_count increments when rsp_ok=0.
  - GAP: req=0 for GAP_CYCLES cycles, then REQ. Used only with RETRY_EN.
- Timeout without RETRY_EN: go to RSP with rsp_ok=0 and rsp_timeout=1.
- Cycle timing with the responder wired directly, command accepted at edge N:
  - req=1 in cycles N+1..N+3; ack first seen at N+3.
  - WAIT from N+4 (req=0). The responder samples req=0 when it returns to idle, so no duplicate transaction starts.
  - done seen at N+5; rsp_valid at N+6; cmd_ready again at N+7.
  - Accept-to-rsp_valid latency is 6 cycles.
- ack and done seen together in REQ: done takes priority; the transaction completes and the status check applies.
- done/data_valid/ack while in IDLE or GAP are ignored; counters do not change.
- rw changes only in IDLE on command accept.
- busy does not affect state transitions.
- Counters hold at 255 once reached.

Optional Feature:
- Macro: BUS_TXN_INITIATOR_RETRY_EN.
- Defined: a timeout in REQ or WAIT goes to GAP when retry count < MAX_RETRY; retry count increments, then the command reissues with the same rw. Once retries are exhausted, go to RSP with rsp_ok=0, rsp_timeout=1. err_count increments once per failed command, not per retry.
- Not defined: a timeout always completes immediately as a failure; GAP state and retry counter are absent.

Test Plan:
- Write: cmd_rw=0 pulse with the responder model -> req high for 3 cycles, rsp_valid at accept+6 with rsp_ok=1, rsp_timeout=0; txn_count=1, err_count=0.
- Read: cmd_rw=1 -> done with data_valid=1 gives rsp_ok=1. Separate case: responder returns data_valid=0 -> rsp_ok=0, err_count increments.
- Ack never asserted, TIMEOUT_CYCLES=16, no retry -> req high for 16 cycles, then rsp_valid with rsp_ok=0, rsp_timeout=1; cmd_ready returns next cycle.
- Retry build, MAX_RETRY=2, ack stuck 0 -> three request windows of 16 cycles separated by 4-cycle req=0 gaps, then one failure response; err_count=1.
- rst_n asserted while in WAIT -> req=0, all outputs and counters 0 at once; no rsp_valid after release; next command completes normally.
- 260 back-to-back writes with cmd_valid held high -> one transaction accepted every 7 cycles; txn_count saturates at 255.
